aes_uart_frame_bridge: RTL and testbench

//  Byte-stream framing controller between UART RX/TX and a block-level AES core.

---
 rtl/aes_uart_frame_bridge.sv | 306 ++++++++++++++++++++++++++++++
 tb/tb_aes_uart_frame_bridge.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_uart_frame_bridge.sv
// Framing controller between a UART byte stream and a block-level AES core.
// Parses header/key/data frames, launches one core operation per block and streams results back.
module aes_uart_frame_bridge #(
  parameter int unsigned KEY_W       = 128,
  parameter int unsigned MAX_BLOCKS  = 4,
  parameter int unsigned TIMEOUT_CYC = 1000000,
  parameter logic [7:0]  ERR_BYTE    = 8'hEE
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             rx_dv_in,
  input  logic [7:0]       rx_byte_in,
  output logic             core_start_out,
  output logic             core_decrypt_out,
  output logic [KEY_W-1:0] core_key_out,
  output logic [127:0]     core_block_out,
  input  logic             core_dv_in,
  input  logic [127:0]     core_block_in,
  output logic             tx_dv_out,
  output logic [7:0]       tx_byte_out,
  input  logic             tx_active_in,
  input  logic             tx_done_in,
  output logic             frame_done_out,
  output logic [2:0]       err_out
);

  localparam int unsigned KEY_BYTES = KEY_W / 8;
  localparam int unsigned KC_W      = $clog2(KEY_BYTES + 1);
  localparam int unsigned TO_W      = $clog2(TIMEOUT_CYC + 1);
  localparam logic [KC_W-1:0] KEY_LAST = KC_W'(KEY_BYTES - 1);
  localparam logic [TO_W-1:0] TO_LAST  = TO_W'(TIMEOUT_CYC - 1);
  localparam logic [TO_W-1:0] TO_MAX   = TO_W'(TIMEOUT_CYC);

  localparam logic [2:0] ERR_NONE    = 3'd0;
  localparam logic [2:0] ERR_HDR     = 3'd1;
  localparam logic [2:0] ERR_NOKEY   = 3'd2;
  localparam logic [2:0] ERR_TIMEOUT = 3'd3;
  localparam logic [2:0] ERR_OVERRUN = 3'd4;

  typedef enum logic [2:0] {S_IDLE, S_KEY, S_DATA, S_DRAIN, S_ERR, S_FLUSH} state_e;

  state_e           state_q, state_d;
  logic [KEY_W-1:0] key_q, key_d, key_sh_q, key_sh_d;
  logic [KC_W-1:0]  key_cnt_q, key_cnt_d;
  logic             key_valid_q, key_valid_d;
  logic             decrypt_q, decrypt_d;
  logic [3:0]       n_blk_q, n_blk_d, rx_blk_q, rx_blk_d, rx_idx_q, rx_idx_d;
  logic [127:0]     in_buf_q, in_buf_d;
  logic             in_full_q, in_full_d;
  logic             core_busy_q, core_busy_d, core_start_q, core_start_d;
  logic [127:0]     core_block_q, core_block_d;
  logic [127:0]     out_buf_q, out_buf_d;
  logic             out_full_q, out_full_d;
  logic [3:0]       tx_idx_q, tx_idx_d, done_blk_q, done_blk_d;
  logic             tx_wait_q, tx_wait_d, tx_dv_q, tx_dv_d;
  logic [7:0]       tx_byte_q, tx_byte_d;
  logic             frame_done_q, frame_done_d;
  logic [2:0]       err_q, err_d;
  logic [TO_W-1:0]  to_cnt_q, to_cnt_d;

  logic             launch_s, tx_fire_s, last_byte_s, timeout_s, hdr_bad_s;
  logic             raise_s;
  logic [2:0]       code_s;
  logic [KEY_W-1:0] key_next_s;

  assign launch_s    = in_full_q && !core_busy_q && !out_full_q;
  assign tx_fire_s   = out_full_q && !tx_active_in && !tx_wait_q;
  assign last_byte_s = tx_done_in && out_full_q && (tx_idx_q == 4'd15);
  assign timeout_s   = (to_cnt_q >= TO_LAST) && !rx_dv_in;
  assign hdr_bad_s   = (rx_byte_in[7:6] != 2'b00) || (rx_byte_in[3:0] == 4'd0) ||
                       (rx_byte_in[3:0] > 4'(MAX_BLOCKS));
  assign key_next_s  = {key_sh_q[KEY_W-9:0], rx_byte_in};

  // Next-state logic: core launch, TX engine, timeout counter and frame FSM
  always_comb begin
    state_d      = state_q;
    key_d        = key_q;
    key_sh_d     = key_sh_q;
    key_cnt_d    = key_cnt_q;
    key_valid_d  = key_valid_q;
    decrypt_d    = decrypt_q;
    n_blk_d      = n_blk_q;
    rx_blk_d     = rx_blk_q;
    rx_idx_d     = rx_idx_q;
    in_buf_d     = in_buf_q;
    in_full_d    = in_full_q;
    core_busy_d  = core_busy_q;
    core_start_d = 1'b0;
    core_block_d = core_block_q;
    out_buf_d    = out_buf_q;
    out_full_d   = out_full_q;
    tx_idx_d     = tx_idx_q;
    done_blk_d   = done_blk_q;
    tx_wait_d    = tx_wait_q;
    tx_dv_d      = 1'b0;
    tx_byte_d    = tx_byte_q;
    frame_done_d = 1'b0;
    err_d        = err_q;
    to_cnt_d     = {TO_W{1'b0}};
    raise_s      = 1'b0;
    code_s       = ERR_NONE;

    if (launch_s) begin
      core_start_d = 1'b1;
      core_block_d = in_buf_q;
      in_full_d    = 1'b0;
      core_busy_d  = 1'b1;
    end
    if (core_dv_in) begin
      out_buf_d   = core_block_in;
      out_full_d  = 1'b1;
      tx_idx_d    = 4'd0;
      core_busy_d = 1'b0;
    end

    // out_buf is shifted so the byte on the wire is always the top byte
    if (tx_fire_s) begin
      tx_dv_d   = 1'b1;
      tx_byte_d = out_buf_q[127:120];
      out_buf_d = {out_buf_q[119:0], 8'h00};
      tx_wait_d = 1'b1;
    end
    if (tx_done_in) begin
      tx_wait_d = 1'b0;
      if (out_full_q) begin
        tx_idx_d = tx_idx_q + 4'd1;
      end else begin
        tx_idx_d = tx_idx_q;
      end
    end
    if (last_byte_s) begin
      out_full_d = 1'b0;
      done_blk_d = done_blk_q + 4'd1;
    end

    if ((state_q == S_KEY) || (state_q == S_DATA) || (state_q == S_FLUSH)) begin
      if (rx_dv_in) begin
        to_cnt_d = {TO_W{1'b0}};
      end else if (to_cnt_q == TO_MAX) begin
        to_cnt_d = to_cnt_q;
      end else begin
        to_cnt_d = to_cnt_q + TO_W'(1);
      end
    end

    case (state_q)
      S_IDLE: begin
        if (rx_dv_in) begin
          if (hdr_bad_s) begin
            raise_s = 1'b1;
            code_s  = ERR_HDR;
          end else if (!rx_byte_in[4] && !key_valid_q) begin
            raise_s = 1'b1;
            code_s  = ERR_NOKEY;
          end else begin
            err_d      = ERR_NONE;
            decrypt_d  = rx_byte_in[5];
            n_blk_d    = rx_byte_in[3:0];
            rx_blk_d   = 4'd0;
            rx_idx_d   = 4'd0;
            done_blk_d = 4'd0;
            key_cnt_d  = {KC_W{1'b0}};
            state_d    = rx_byte_in[4] ? S_KEY : S_DATA;
          end
        end
      end
      S_KEY: begin
        if (rx_dv_in) begin
          key_sh_d  = key_next_s;
          key_cnt_d = key_cnt_q + KC_W'(1);
          if (key_cnt_q == KEY_LAST) begin
            key_d       = key_next_s;
            key_valid_d = 1'b1;
            key_cnt_d   = {KC_W{1'b0}};
            state_d     = S_DATA;
          end
        end else if (timeout_s) begin
          raise_s = 1'b1;
          code_s  = ERR_TIMEOUT;
        end
      end
      S_DATA: begin
        if (rx_dv_in) begin
          if (in_full_q) begin
            raise_s = 1'b1;
            code_s  = ERR_OVERRUN;
          end else begin
            in_buf_d = {in_buf_q[119:0], rx_byte_in};
            rx_idx_d = rx_idx_q + 4'd1;
            if (rx_idx_q == 4'd15) begin
              in_full_d = 1'b1;
              rx_blk_d  = rx_blk_q + 4'd1;
              if ((rx_blk_q + 4'd1) == n_blk_q) begin
                state_d = S_DRAIN;
              end
            end
          end
        end else if (timeout_s) begin
          raise_s = 1'b1;
          code_s  = ERR_TIMEOUT;
        end
      end
      S_DRAIN: begin
        if (rx_dv_in) begin
          raise_s = 1'b1;
          code_s  = ERR_HDR;
        end else if (last_byte_s && ((done_blk_q + 4'd1) == n_blk_q)) begin
          frame_done_d = 1'b1;
          state_d      = S_IDLE;
        end
      end
      // error byte goes out only after any launched block has been fully sent
      S_ERR: begin
        if (!core_busy_q && !out_full_q && !tx_wait_q && !tx_active_in) begin
          tx_dv_d   = 1'b1;
          tx_byte_d = ERR_BYTE;
          tx_wait_d = 1'b1;
          state_d   = S_FLUSH;
        end
      end
      S_FLUSH: begin
        if (timeout_s) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // a partially loaded key is never trusted
    if (raise_s) begin
      state_d     = S_ERR;
      err_d       = code_s;
      in_full_d   = 1'b0;
      rx_idx_d    = 4'd0;
      key_cnt_d   = {KC_W{1'b0}};
      key_valid_d = key_valid_q && (state_q != S_KEY);
    end
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      key_q        <= {KEY_W{1'b0}};
      key_sh_q     <= {KEY_W{1'b0}};
      key_cnt_q    <= {KC_W{1'b0}};
      key_valid_q  <= 1'b0;
      decrypt_q    <= 1'b0;
      n_blk_q      <= 4'd0;
      rx_blk_q     <= 4'd0;
      rx_idx_q     <= 4'd0;
      in_buf_q     <= 128'd0;
      in_full_q    <= 1'b0;
      core_busy_q  <= 1'b0;
      core_start_q <= 1'b0;
      core_block_q <= 128'd0;
      out_buf_q    <= 128'd0;
      out_full_q   <= 1'b0;
      tx_idx_q     <= 4'd0;
      done_blk_q   <= 4'd0;
      tx_wait_q    <= 1'b0;
      tx_dv_q      <= 1'b0;
      tx_byte_q    <= 8'd0;
      frame_done_q <= 1'b0;
      err_q        <= 3'd0;
      to_cnt_q     <= {TO_W{1'b0}};
    end else begin
      state_q      <= state_d;
      key_q        <= key_d;
      key_sh_q     <= key_sh_d;
      key_cnt_q    <= key_cnt_d;
      key_valid_q  <= key_valid_d;
      decrypt_q    <= decrypt_d;
      n_blk_q      <= n_blk_d;
      rx_blk_q     <= rx_blk_d;
      rx_idx_q     <= rx_idx_d;
      in_buf_q     <= in_buf_d;
      in_full_q    <= in_full_d;
      core_busy_q  <= core_busy_d;
      core_start_q <= core_start_d;
      core_block_q <= core_block_d;
      out_buf_q    <= out_buf_d;
      out_full_q   <= out_full_d;
      tx_idx_q     <= tx_idx_d;
      done_blk_q   <= done_blk_d;
      tx_wait_q    <= tx_wait_d;
      tx_dv_q      <= tx_dv_d;
      tx_byte_q    <= tx_byte_d;
      frame_done_q <= frame_done_d;
      err_q        <= err_d;
      to_cnt_q     <= to_cnt_d;
    end
  end

  assign core_start_out   = core_start_q;
  assign core_decrypt_out = decrypt_q;
  assign core_key_out     = key_q;
  assign core_block_out   = core_block_q;
  assign tx_dv_out        = tx_dv_q;
  assign tx_byte_out      = tx_byte_q;
  assign frame_done_out   = frame_done_q;
  assign err_out          = err_q;

endmodule

// File: tb/tb_aes_uart_frame_bridge.sv
// Self-checking bench for aes_uart_frame_bridge: header-error table plus directed frame sequences,
// with behavioural AES-core and UART-TX responders.
module tb_aes_uart_frame_bridge;
  localparam int KEY_W = 128;
  localparam int TO    = 1000;
  localparam int GAP   = 8;
  localparam logic [127:0] FIPS_PT = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] FIPS_CT = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] FIPS_KY = 128'h000102030405060708090a0b0c0d0e0f;

  logic             clk = 1'b0;
  logic             rst_n, rx_dv_in, core_dv_in, tx_active_in, tx_done_in;
  logic [7:0]       rx_byte_in, tx_byte_out;
  logic             core_start_out, core_decrypt_out, tx_dv_out, frame_done_out;
  logic [KEY_W-1:0] core_key_out;
  logic [127:0]     core_block_out, core_block_in;
  logic [2:0]       err_out;

  int total = 0;
  int bad = 0;
  int n_start = 0;
  int n_done = 0;
  int core_lat = 5;
  logic [7:0]       tx_q[$];
  logic [KEY_W-1:0] last_key;
  logic             last_dec;
  logic [127:0]     last_blk;

  aes_uart_frame_bridge #(.KEY_W(KEY_W), .MAX_BLOCKS(4), .TIMEOUT_CYC(TO), .ERR_BYTE(8'hEE)) dut (
    .clk(clk), .rst_n(rst_n), .rx_dv_in(rx_dv_in), .rx_byte_in(rx_byte_in),
    .core_start_out(core_start_out), .core_decrypt_out(core_decrypt_out),
    .core_key_out(core_key_out), .core_block_out(core_block_out),
    .core_dv_in(core_dv_in), .core_block_in(core_block_in),
    .tx_dv_out(tx_dv_out), .tx_byte_out(tx_byte_out), .tx_active_in(tx_active_in),
    .tx_done_in(tx_done_in), .frame_done_out(frame_done_out), .err_out(err_out)
  );

  always #5 clk = ~clk;

  function automatic logic [127:0] core_fn(input logic [127:0] b);
    if (b == FIPS_PT) return FIPS_CT;
    return b ^ {16{8'h5A}};
  endfunction

  // Pulse monitor
  initial begin
    forever begin
      @(posedge clk); #1;
      if (core_start_out) begin
        n_start++;
        last_key = core_key_out;
        last_dec = core_decrypt_out;
        last_blk = core_block_out;
      end
      if (frame_done_out) n_done++;
    end
  end

  // AES core responder
  initial begin
    logic [127:0] b;
    core_dv_in = 1'b0;
    core_block_in = 128'd0;
    forever begin
      @(posedge clk); #1;
      core_dv_in = 1'b0;
      if (core_start_out) begin
        b = core_block_out;
        repeat (core_lat) @(posedge clk);
        #1;
        core_block_in = core_fn(b);
        core_dv_in = 1'b1;
      end
    end
  end

  // UART TX responder
  initial begin
    tx_active_in = 1'b0;
    tx_done_in = 1'b0;
    forever begin
      @(posedge clk); #1;
      tx_done_in = 1'b0;
      if (tx_dv_out) begin
        tx_q.push_back(tx_byte_out);
        tx_active_in = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        tx_active_in = 1'b0;
        tx_done_in = 1'b1;
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_byte_in = b;
    rx_dv_in = 1'b1;
    @(posedge clk); #1;
    rx_dv_in = 1'b0;
    wait_cyc(GAP);
  endtask

  task automatic wait_tx(input string name, input int n, input int budget);
    int k = 0;
    while (tx_q.size() < n && k < budget) begin
      @(posedge clk); #1;
      k++;
    end
    chk(name, tx_q.size(), n);
  endtask

  typedef struct packed {
    logic [7:0] hdr;
    logic [2:0] err;
  } hvec_t;

  initial begin
    hvec_t hv [7];
    int base, s0, d0, ov, k;
    logic [127:0] blk, exp_blk;
    logic [127:0] exp_q [$];

    hv[0] = '{hdr: 8'h01, err: 3'd2};
    hv[1] = '{hdr: 8'h10, err: 3'd1};
    hv[2] = '{hdr: 8'hC1, err: 3'd1};
    hv[3] = '{hdr: 8'h05, err: 3'd1};
    hv[4] = '{hdr: 8'h15, err: 3'd1};
    hv[5] = '{hdr: 8'h80, err: 3'd1};
    hv[6] = '{hdr: 8'h24, err: 3'd2};

    rst_n = 1'b0;
    rx_dv_in = 1'b0;
    rx_byte_in = 8'd0;
    wait_cyc(2);
    chk("rst_core_start", core_start_out, 0);
    chk("rst_decrypt", core_decrypt_out, 0);
    chk("rst_key", core_key_out, 0);
    chk("rst_block", core_block_out, 0);
    chk("rst_tx_dv", tx_dv_out, 0);
    chk("rst_tx_byte", tx_byte_out, 0);
    chk("rst_frame_done", frame_done_out, 0);
    chk("rst_err", err_out, 0);
    rst_n = 1'b1;
    wait_cyc(2);

    // header error table (no key loaded yet)
    s0 = n_start;
    for (int i = 0; i < 7; i++) begin
      base = tx_q.size();
      send_byte(hv[i].hdr);
      wait_cyc(20);
      chk("hdr_err", err_out, hv[i].err);
      chk("hdr_ee_count", tx_q.size() - base, 1);
      if (tx_q.size() > base) chk("hdr_ee_value", tx_q[base], 8'hEE);
      wait_cyc(TO + 20);
    end
    chk("hdr_no_start", n_start - s0, 0);

    // FIPS-197 single block with key load, encrypt
    base = tx_q.size(); s0 = n_start; d0 = n_done;
    send_byte(8'h11);
    for (int i = 0; i < 16; i++) send_byte(8'(i));
    for (int i = 0; i < 16; i++) send_byte(8'(i * 17));
    wait_tx("fips_tx_count", base + 16, 500);
    wait_cyc(20);
    chk("fips_starts", n_start - s0, 1);
    chk("fips_key", last_key, FIPS_KY);
    chk("fips_block", last_blk, FIPS_PT);
    chk("fips_decrypt", last_dec, 0);
    exp_blk = FIPS_CT;
    for (int j = 0; j < 16; j++) chk("fips_byte", tx_q[base + j], exp_blk[127 - 8 * j -: 8]);
    chk("fips_done", n_done - d0, 1);
    chk("fips_err", err_out, 0);

    // three-block decrypt frame with fresh key; block 2 RX overlaps block 1 TX
    base = tx_q.size(); s0 = n_start; d0 = n_done; ov = 0;
    exp_q.delete();
    send_byte(8'h33);
    for (int i = 0; i < 16; i++) send_byte(8'(8'hF0 + i));
    for (int b = 0; b < 3; b++) begin
      blk = 128'd0;
      for (int i = 0; i < 16; i++) begin
        if (b == 1 && i == 8) ov = tx_q.size() - base;
        send_byte(8'(b * 16 + i));
        blk = {blk[119:0], 8'(b * 16 + i)};
      end
      exp_q.push_back(core_fn(blk));
    end
    chk("multi_overlap", ov > 0, 1);
    wait_tx("multi_tx_count", base + 48, 2000);
    wait_cyc(20);
    chk("multi_starts", n_start - s0, 3);
    chk("multi_decrypt", last_dec, 1);
    chk("multi_key", last_key, 128'hf0f1f2f3f4f5f6f7f8f9fafbfcfdfeff);
    for (int j = 0; j < 48; j++) begin
      exp_blk = exp_q[j / 16];
      chk("multi_byte", tx_q[base + j], exp_blk[127 - 8 * (j % 16) -: 8]);
    end
    chk("multi_done", n_done - d0, 1);
    chk("multi_err", err_out, 0);

    // inter-byte timeout, then a byte during flush is ignored
    base = tx_q.size(); s0 = n_start;
    send_byte(8'h01);
    for (int i = 0; i < 5; i++) send_byte(8'h77);
    wait_cyc(TO - 10 - GAP);
    chk("to_not_yet", err_out, 0);
    k = 0;
    while (err_out !== 3'd3 && k < 30) begin
      wait_cyc(1);
      k++;
    end
    chk("to_err", err_out, 3);
    wait_cyc(20);
    chk("to_ee_count", tx_q.size() - base, 1);
    if (tx_q.size() > base) chk("to_ee_value", tx_q[base], 8'hEE);
    wait_cyc(100);
    send_byte(8'h11);
    wait_cyc(10);
    chk("flush_ignore_err", err_out, 3);
    chk("flush_no_start", n_start - s0, 0);
    wait_cyc(TO + 20);

    // normal frame after flush, retained key
    base = tx_q.size(); s0 = n_start; d0 = n_done;
    send_byte(8'h01);
    blk = 128'd0;
    for (int i = 0; i < 16; i++) begin
      send_byte(8'(8'hA0 + i));
      blk = {blk[119:0], 8'(8'hA0 + i)};
    end
    exp_blk = core_fn(blk);
    wait_tx("post_tx_count", base + 16, 500);
    wait_cyc(20);
    chk("post_starts", n_start - s0, 1);
    chk("post_key", last_key, 128'hf0f1f2f3f4f5f6f7f8f9fafbfcfdfeff);
    chk("post_decrypt", last_dec, 0);
    for (int j = 0; j < 16; j++) chk("post_byte", tx_q[base + j], exp_blk[127 - 8 * j -: 8]);
    chk("post_done", n_done - d0, 1);
    chk("post_err", err_out, 0);

    // overrun while the core is stalled
    core_lat = 400;
    base = tx_q.size(); s0 = n_start;
    send_byte(8'h03);
    blk = 128'd0;
    for (int i = 0; i < 16; i++) begin
      send_byte(8'(8'h40 + i));
      blk = {blk[119:0], 8'(8'h40 + i)};
    end
    exp_blk = core_fn(blk);
    for (int i = 0; i < 17; i++) send_byte(8'(8'h50 + i));
    wait_cyc(5);
    chk("ovr_err", err_out, 4);
    chk("ovr_no_tx_yet", tx_q.size() - base, 0);
    wait_tx("ovr_tx_count", base + 17, 1500);
    wait_cyc(30);
    chk("ovr_tx_total", tx_q.size() - base, 17);
    for (int j = 0; j < 16; j++) chk("ovr_byte", tx_q[base + j], exp_blk[127 - 8 * j -: 8]);
    chk("ovr_ee", tx_q[base + 16], 8'hEE);
    chk("ovr_starts", n_start - s0, 1);
    core_lat = 5;
    wait_cyc(TO + 50);

    // reset mid-data discards frame and key
    s0 = n_start;
    send_byte(8'h11);
    for (int i = 0; i < 16; i++) send_byte(8'(8'h30 + i));
    for (int i = 0; i < 5; i++) send_byte(8'h99);
    rst_n = 1'b0;
    wait_cyc(1);
    rst_n = 1'b1;
    chk("mid_rst_err", err_out, 0);
    chk("mid_rst_key", core_key_out, 0);
    wait_cyc(40);
    chk("mid_rst_no_start", n_start - s0, 0);
    base = tx_q.size();
    send_byte(8'h01);
    wait_cyc(20);
    chk("mid_rst_nokey", err_out, 2);
    chk("mid_rst_ee", tx_q.size() - base, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
